// File: rtl/mcycle_ctrl_if.sv
// mcycle_ctrl_if: pipeline-side signals of the multi-cycle MUL/DIV sequencing controller.
//   slave  modport: used by mcycle_ctrl (consumes E/D-stage info, drives start/done/stall/flush).
//   master modport: used by the pipeline (or a testbench) on the other side.
//   E-stage inputs : MReqE, DivE, RegWriteE, WA3E
//   D-stage inputs : MReqD, RA1D, RA2D, RA3D, WA3D, RegWriteD
//   outputs        : M_StartE, M_DoneE, StallF, StallD, FlushE, FlushM, Busy
interface mcycle_ctrl_if;
    logic       MReqE;
    logic       DivE;
    logic       RegWriteE;
    logic [3:0] WA3E;
    logic       MReqD;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] RA3D;
    logic [3:0] WA3D;
    logic       RegWriteD;
    logic       M_StartE;
    logic       M_DoneE;
    logic       StallF;
    logic       StallD;
    logic       FlushE;
    logic       FlushM;
    logic       Busy;

    modport slave (
        input  MReqE, DivE, RegWriteE, WA3E, MReqD, RA1D, RA2D, RA3D, WA3D, RegWriteD,
        output M_StartE, M_DoneE, StallF, StallD, FlushE, FlushM, Busy
    );

    modport master (
        output MReqE, DivE, RegWriteE, WA3E, MReqD, RA1D, RA2D, RA3D, WA3D, RegWriteD,
        input  M_StartE, M_DoneE, StallF, StallD, FlushE, FlushM, Busy
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: sequencing controller for the multi-cycle MUL/DIV unit.
//   Detects a MUL/DIV in Execute, issues the one-cycle start pulse, times the unit's fixed
//   latency and drives stall/flush controls, then asserts the done select for one cycle so the
//   saved instruction replays through Execute.
// Ports:
//   CLK    - core clock, rising edge
//   RESETn - asynchronous active-low reset
//   bus    - mcycle_ctrl_if.slave (E/D-stage inputs, start/done/stall/flush/busy outputs)
// Optional feature: define MCYCLE_OVERLAP_EN to let independent instructions proceed while the
//   unit runs; hazards against the in-flight op then stall F/D, and a SLOT state empties E
//   before the replay.
module mcycle_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 33,
    parameter int unsigned CNT_W   = 6
) (
    input logic          CLK,
    input logic          RESETn,
    mcycle_ctrl_if.slave bus
);

`ifdef MCYCLE_OVERLAP_EN
    typedef enum logic [1:0] {StIdle, StRun, StSlot, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       wa3r_q, wa3r_d;
    logic             reg_write_r_q, reg_write_r_d;

    // Outputs must read 0 while reset is held, even if MReqE is high.
    logic req_e;
    assign req_e = bus.MReqE & RESETn;

    logic hazard;
`ifdef MCYCLE_OVERLAP_EN
    logic track;
    // r15 is never tracked, so a saved destination of 15 never matches.
    assign track  = reg_write_r_q & (wa3r_q != 4'd15);
    assign hazard = bus.MReqD
                  | (track & ((bus.RA1D == wa3r_q) | (bus.RA2D == wa3r_q)
                              | (bus.RA3D == wa3r_q)))
                  | (track & bus.RegWriteD & (bus.WA3D == wa3r_q));
`else
    // Pipeline is fully frozen while running; D-stage info is irrelevant.
    assign hazard = 1'b1;
    logic unused_d_stage;
    assign unused_d_stage = ^{bus.MReqD, bus.RA1D, bus.RA2D, bus.RA3D, bus.WA3D,
                              bus.RegWriteD, wa3r_q, reg_write_r_q};
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wa3r_q        <= '0;
            reg_write_r_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wa3r_q        <= wa3r_d;
            reg_write_r_q <= reg_write_r_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wa3r_d        = wa3r_q;
        reg_write_r_d = reg_write_r_q;
        bus.M_StartE  = 1'b0;
        bus.M_DoneE   = 1'b0;
        bus.StallF    = 1'b0;
        bus.StallD    = 1'b0;
        bus.FlushE    = 1'b0;
        bus.FlushM    = 1'b0;
        bus.Busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // Start decodes only from registered state and MReqE, so it is glitch-free
                // before the save registers capture on the falling edge.
                if (req_e) begin
                    bus.M_StartE  = 1'b1;
                    bus.StallF    = 1'b1;
                    bus.StallD    = 1'b1;
                    bus.FlushE    = 1'b1;
                    bus.FlushM    = 1'b1;
                    cnt_d         = bus.DivE ? DivLoad : MulLoad;
                    wa3r_d        = bus.WA3E;
                    reg_write_r_d = bus.RegWriteE;
                    state_d       = StRun;
                end
            end
            StRun: begin
                bus.StallF = hazard;
                bus.StallD = hazard;
                bus.FlushE = hazard;
                // Test for zero before decrementing so the counter never wraps.
                if (cnt_q == '0) begin
`ifdef MCYCLE_OVERLAP_EN
                    state_d = StSlot;
`else
                    state_d = StDone;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MCYCLE_OVERLAP_EN
            StSlot: begin
                // Empty E so the replay has a free slot.
                bus.StallF = 1'b1;
                bus.StallD = 1'b1;
                bus.FlushE = 1'b1;
                state_d    = StDone;
            end
`endif
            StDone: begin
                bus.M_DoneE = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed self-checking bench for mcycle_ctrl.
//   dut  : MUL_LAT=4, DIV_LAT=33
//   dut1 : MUL_LAT=1 (shares all inputs with dut)
// Observed vector bit order: {M_StartE, M_DoneE, StallF, StallD, FlushE, FlushM, Busy}.
module tb_mcycle_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mcycle_ctrl_if if0 ();
    mcycle_ctrl_if if1 ();

    assign if1.MReqE     = if0.MReqE;
    assign if1.DivE      = if0.DivE;
    assign if1.RegWriteE = if0.RegWriteE;
    assign if1.WA3E      = if0.WA3E;
    assign if1.MReqD     = if0.MReqD;
    assign if1.RA1D      = if0.RA1D;
    assign if1.RA2D      = if0.RA2D;
    assign if1.RA3D      = if0.RA3D;
    assign if1.WA3D      = if0.WA3D;
    assign if1.RegWriteD = if0.RegWriteD;

    mcycle_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (if0)
    );

    mcycle_ctrl #(.MUL_LAT(1), .DIV_LAT(33), .CNT_W(6)) dut1 (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (if1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] obs(input int sel);
        if (sel == 0)
            return {if0.M_StartE, if0.M_DoneE, if0.StallF, if0.StallD,
                    if0.FlushE, if0.FlushM, if0.Busy};
        return {if1.M_StartE, if1.M_DoneE, if1.StallF, if1.StallD,
                if1.FlushE, if1.FlushM, if1.Busy};
    endfunction

    // Expected outputs in cycle t after a start at T0, no hazards from D.
    function automatic logic [6:0] exp_vec(input int t, input int lat);
        logic st, dn, stall, bsy;
`ifdef MCYCLE_OVERLAP_EN
        stall = (t == 0) || (t == lat + 1);
        dn    = (t == lat + 2);
        bsy   = (t >= 1) && (t <= lat + 2);
`else
        stall = (t <= lat);
        dn    = (t == lat + 1);
        bsy   = (t >= 1) && (t <= lat + 1);
`endif
        st = (t == 0);
        return {st, dn, stall, stall, stall, st, bsy};
    endfunction

    task automatic clear_inputs();
        if0.MReqE = 0; if0.DivE = 0; if0.RegWriteE = 0; if0.WA3E = 0;
        if0.MReqD = 0; if0.RA1D = 0; if0.RA2D = 0; if0.RA3D = 0;
        if0.WA3D = 0; if0.RegWriteD = 0;
    endtask

    task automatic run_op(input string tag, input bit div, input int lat, input int sel);
        repeat (2) @(posedge clk);
        #1;
        if0.MReqE = 1; if0.DivE = div; if0.RegWriteE = 1; if0.WA3E = 4'd3;
        for (int t = 0; t <= lat + 3; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
                if0.MReqE = 0; if0.DivE = 0;
            end
            @(negedge clk);
            check($sformatf("%s_t%0d", tag, t), {25'b0, obs(sel)}, {25'b0, exp_vec(t, lat)});
        end
    endtask

`ifdef MCYCLE_OVERLAP_EN
    // mode 0: D reads r5 at T1 then r3 (hazard) from T2; mode 1: MReqD from T1.
    task automatic run_ov(input string tag, input int mode);
        int lat = 4;
        int hz  = (mode == 0) ? 2 : 1;
        logic st, dn, stall, bsy;
        repeat (2) @(posedge clk);
        #1;
        if0.MReqE = 1; if0.RegWriteE = 1; if0.WA3E = 4'd3;
        for (int t = 0; t <= lat + 3; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
                if0.MReqE = 0;
                if (mode == 0) if0.RA1D = (t == 1) ? 4'd5 : (t <= lat + 2) ? 4'd3 : 4'd0;
                else           if0.MReqD = (t <= lat + 2);
            end
            @(negedge clk);
            st    = (t == 0);
            stall = (t == 0) || ((t >= hz) && (t <= lat + 1));
            dn    = (t == lat + 2);
            bsy   = (t >= 1) && (t <= lat + 2);
            check($sformatf("%s_t%0d", tag, t), {25'b0, obs(0)},
                  {25'b0, st, dn, stall, stall, stall, st, bsy});
        end
        clear_inputs();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_hold", {25'b0, obs(0)}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {25'b0, obs(0)}, 32'd0);
        check("reset_state1", {25'b0, obs(1)}, 32'd0);

        run_op("mul", 1'b0, 4, 0);
        run_op("div", 1'b1, 33, 0);

        // Reset pulsed at T2 of a DIV.
        repeat (2) @(posedge clk);
        #1 if0.MReqE = 1; if0.DivE = 1;
        @(posedge clk); #1 if0.MReqE = 0; if0.DivE = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("div_t2_busy", {31'b0, if0.Busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", {25'b0, obs(0)}, 32'd0);
        if0.MReqE = 1;
        #1;
        check("rst_start_gated", {31'b0, if0.M_StartE}, 32'd0);
        if0.MReqE = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_op("mul_after_rst", 1'b0, 4, 0);

`ifdef MCYCLE_OVERLAP_EN
        run_ov("ov_raw", 0);
        run_ov("ov_struct", 1);
`endif

        run_op("mul_lat1", 1'b0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Sequencing controller for the multi-cycle MUL/DIV unit in the pipelined ARM core. It detects a multi-cycle op in Execute and issues the one-cycle start pulse that the E-stage save registers and the unit consume. It times the unit's fixed latency and drives the pipeline stall and flush controls. When the result is ready, it asserts the done select that replays the saved instruction through Execute.

## Interface
Parameters:
- MUL_LAT, 4: multiply latency in cycles. Legal range 1..2^CNT_W.
- DIV_LAT, 33: divide latency in cycles. Legal range 1..2^CNT_W.
- CNT_W, 6: latency counter width.

Ports:
- CLK  in  1  core clock. All state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- MReqE  in  1  E-stage instruction is a MUL/DIV that passed its condition check.
- DivE  in  1  with MReqE: 0 = MUL, 1 = DIV.
- RegWriteE  in  1  the op writes a register.
- WA3E  in  4  the op's destination register.
- MReqD  in  1  D-stage instruction is a MUL/DIV.
- RA1D, RA2D, RA3D  in  4 each  D-stage source registers.
- WA3D  in  4  D-stage destination register.
- RegWriteD  in  1  the D-stage instruction writes a register.
- M_StartE  out  1  start pulse to the unit and the E-stage save registers. Combinational.
- M_DoneE  out  1  done select. Replays the saved instruction and result through E.
- StallF, StallD  out  1 each  hold the Fetch and Decode registers.
- FlushE  out  1  load a bubble into the E register at the next edge.
- FlushM  out  1  load a bubble into the M register at the next edge.
- Busy  out  1  state is not IDLE.

## Operation
- States: IDLE, RUN, SLOT (only when MCYCLE_OVERLAP_EN is defined), DONE.
- Internal registers: cnt[CNT_W-1:0], WA3R[3:0], RegWriteR.
- IDLE:
  - If MReqE=1: M_StartE=1, StallF=1, StallD=1, FlushE=1, FlushM=1.
  - The original op never reaches M.
  - At the edge: cnt ← (DivE ? DIV_LAT : MUL_LAT) − 1, latch WA3R and RegWriteR, go to RUN.
- RUN:
  - cnt decrements by 1 each cycle.
  - When cnt==0, next state is DONE (SLOT if overlap is enabled).
  - Without overlap: StallF=1, StallD=1, FlushE=1 for every RUN cycle.
- SLOT (overlap only): StallF=1, StallD=1, FlushE=1. This empties the E slot, then go to DONE.
- DONE:
  - M_DoneE=1 for exactly one cycle. Stall and flush outputs are 0.
  - E holds a bubble, so no new MReqE is possible.
  - Next state is IDLE.
- The unit holds its result stable from the end of its latency until the next M_StartE. The controller samples nothing from the unit.
- MReqE is ignored outside IDLE. It cannot occur there without overlap, because E holds a bubble.
- Reset mid-operation: return to IDLE and clear cnt, WA3R and RegWriteR. The in-flight op is dropped.
- Reset value of every output: 0.

## Timing
- Start cycle T0:
  - M_StartE is high for the whole cycle.
  - The save registers capture on the falling edge of T0, so M_StartE must be glitch-free before that edge. It decodes only from the registered state and MReqE.
- Without overlap: RUN occupies T1..T_LAT and DONE is T_LAT+1. Example: MUL_LAT=4 gives DONE at T5.
- With overlap: SLOT is T_LAT+1 and DONE is T_LAT+2.
- With LAT=1: cnt loads 0 and RUN lasts exactly one cycle.
- Counter wraparound must not occur. cnt is checked for 0 before decrementing.
- Busy is high from T1 through DONE.

## Configuration
- MCYCLE_OVERLAP_EN, undefined: F, D and E are fully frozen (F and D stalled, E bubbled) from T0 through the last RUN cycle.
- MCYCLE_OVERLAP_EN, defined: independent instructions proceed during RUN. A hazard in RUN or SLOT forces StallF=1, StallD=1, FlushE=1. A hazard is any of:
  - MReqD=1 (structural);
  - RegWriteR=1 and RA1D, RA2D or RA3D equals WA3R (RAW);
  - RegWriteR=1, RegWriteD=1 and WA3D equals WA3R (WAW).
- Register r15 is never tracked: WA3R=15 disables the hazard match.
- The SLOT state always exists in this mode.

## Test plan
- MUL without overlap, MUL_LAT=4: MReqE=1 at T0 → M_StartE high only at T0, StallF/StallD high T0..T4, M_DoneE high only at T5, Busy high T1..T5.
- DIV without overlap, DIV_LAT=33: MReqE=1, DivE=1 at T0 → M_DoneE at T34 only, FlushM high only at T0.
- Overlap, MUL with WA3E=3; D-stage reads r5 then r3 at T2 → no stall at T1; stall at T2 held through SLOT (T5); M_DoneE at T6.
- Overlap, MReqD=1 at T1 → stalled until DONE. The second op starts at the earliest in the cycle after DONE.
- RESETn pulsed low at T2 of a DIV → all outputs 0 asynchronously, Busy=0. A new MReqE after release starts cleanly with DONE at T_LAT+1.
- MUL_LAT=1: MReqE at T0 → RUN at T1 only, M_DoneE at T2.
